// File: rtl/inst_ram_arb_if.sv
// Bundle of fetch, loader and RAM-side signals shared by the instruction RAM arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the requesters and the RAM.
interface inst_ram_arb_if #(
   parameter int ADDR_W = 10,
   parameter int MEM_W  = 8,
   parameter int INST_W = 32
);
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_gnt;
   logic              fetch_valid;
   logic [INST_W-1:0] fetch_data;

   logic              ld_valid;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic [INST_W-1:0] ld_data;
   logic              ld_done;
   logic [15:0]       ld_count;

   logic [ADDR_W-1:0] ram_addr;
   logic [MEM_W-1:0]  ram_din;
   logic              ram_en;
   logic              ram_we;
   logic [INST_W-1:0] ram_dout;

   modport slave (
      input  fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, ram_dout,
      output fetch_gnt, fetch_valid, fetch_data, ld_ready, ld_done, ld_count,
             ram_addr, ram_din, ram_en, ram_we
   );

   modport master (
      output fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, ram_dout,
      input  fetch_gnt, fetch_valid, fetch_data, ld_ready, ld_done, ld_count,
             ram_addr, ram_din, ram_en, ram_we
   );
endinterface

// File: rtl/inst_ram_arb.sv
// Shares the single byte-wide instruction RAM port between fetch reads and loader word writes.
// Each accepted loader word becomes four uninterrupted byte writes, always followed by an IDLE cycle.
module inst_ram_arb #(
   parameter int ADDR_W = 10,
   parameter int MEM_W  = 8,
   parameter int INST_W = 32
) (
   input logic           clk,
   input logic           rst,
   inst_ram_arb_if.slave bus
);
   typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, WR3} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [INST_W-1:0] wdata_q, wdata_d;
   logic [15:0]       ld_count_q, ld_count_d;
   logic              fetch_valid_q;
   logic [INST_W-1:0] fetch_data_q;
   logic [ADDR_W-1:0] addr_hold_q;
   logic [MEM_W-1:0]  din_hold_q;

   logic              fetch_gnt, ld_ready, ld_done, ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [MEM_W-1:0]  ram_din;
   logic [1:0]        byte_idx;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d    = state_q;
      base_d     = base_q;
      wdata_d    = wdata_q;
      ld_count_d = ld_count_q;
      fetch_gnt  = 1'b0;
      ld_ready   = 1'b0;
      ld_done    = 1'b0;
      ram_en     = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = addr_hold_q;
      ram_din    = din_hold_q;
      byte_idx   = 2'd0;

      case (state_q)
         IDLE: begin
            ld_ready  = 1'b1;
            fetch_gnt = bus.fetch_req;
            if (bus.fetch_req) begin
               ram_en   = 1'b1;
               ram_addr = bus.fetch_addr;
            end
            // The accept cycle leaves the RAM port to fetch; the word is written in the next four cycles.
            if (bus.ld_valid) begin
               base_d  = bus.ld_addr & ~ADDR_W'(3);
               wdata_d = bus.ld_data;
               state_d = WR0;
            end
         end
         WR0: begin
            byte_idx = 2'd0;
            state_d  = WR1;
         end
         WR1: begin
            byte_idx = 2'd1;
            state_d  = WR2;
         end
         WR2: begin
            byte_idx = 2'd2;
            state_d  = WR3;
         end
         WR3: begin
            byte_idx = 2'd3;
            state_d  = IDLE;
            ld_done  = 1'b1;
            if (ld_count_q != 16'hFFFF) ld_count_d = ld_count_q + 16'd1;
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE) begin
         ram_en   = 1'b1;
         ram_we   = 1'b1;
         ram_addr = base_q + ADDR_W'(byte_idx);
         ram_din  = wdata_q[byte_idx*MEM_W +: MEM_W];
      end

      // State is already forced to IDLE during reset, but IDLE would still grant a live fetch_req.
      if (rst) begin
         fetch_gnt = 1'b0;
         ld_ready  = 1'b0;
         ld_done   = 1'b0;
         ram_en    = 1'b0;
         ram_we    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         base_q        <= '0;
         wdata_q       <= '0;
         ld_count_q    <= '0;
         fetch_valid_q <= 1'b0;
         fetch_data_q  <= '0;
         addr_hold_q   <= '0;
         din_hold_q    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q       <= state_d;
         base_q        <= base_d;
         wdata_q       <= wdata_d;
         ld_count_q    <= ld_count_d;
         fetch_valid_q <= fetch_gnt;
         fetch_data_q  <= bus.ram_dout;
         addr_hold_q   <= ram_addr;
         din_hold_q    <= ram_din;
      end
   end

   assign bus.fetch_gnt   = fetch_gnt;
   assign bus.fetch_valid = fetch_valid_q;
   assign bus.fetch_data  = fetch_data_q;
   assign bus.ld_ready    = ld_ready;
   assign bus.ld_done     = ld_done;
   assign bus.ld_count    = ld_count_q;
   assign bus.ram_addr    = ram_addr;
   assign bus.ram_din     = ram_din;
   assign bus.ram_en      = ram_en;
   assign bus.ram_we      = ram_we;
endmodule

// File: tb/tb_inst_ram_arb.sv
// Self-checking bench for inst_ram_arb: directed steps plus random traffic against a queue-based model.
// The model keeps a list of pending byte writes and its own copy of memory.
module tb_inst_ram_arb;
   localparam int AW = 10;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   inst_ram_arb_if #(.ADDR_W(AW)) bus ();
   inst_ram_arb #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   inst_ram_arb_if #(.ADDR_W(2)) sbus ();
   inst_ram_arb #(.ADDR_W(2)) sdut (.clk(clk), .rst(rst), .bus(sbus));

   // Behavioural RAM behind the main DUT, written by the bench from sampled port values.
   logic [7:0] ram [DEPTH];
   assign bus.ram_dout = {ram[AW'(bus.ram_addr + 10'd3)], ram[AW'(bus.ram_addr + 10'd2)],
                          ram[AW'(bus.ram_addr + 10'd1)], ram[bus.ram_addr]};
   assign sbus.ram_dout = 32'h0;
   assign sbus.fetch_req = 1'b0;
   assign sbus.fetch_addr = 2'd0;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [7:0]    d;
   } wr_t;

   wr_t         pend[$];
   logic [7:0]  mmem [DEPTH];
   logic        exp_fv;
   logic [31:0] exp_fd;
   logic [15:0] exp_cnt;
   logic [AW-1:0] last_addr;
   logic [7:0]  last_din;
   bit          have_addr, have_din;

   int checks = 0;
   int errors = 0;
   int n_gnt, n_done, cur_gap, max_gap;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      pend.delete();
      exp_fv = 1'b0;
      exp_fd = 32'h0;
      exp_cnt = 16'h0;
      have_addr = 1'b0;
      have_din = 1'b0;
   endtask

   task automatic apply_rst(input logic v);
      rst = v;
      if (v) reset_model();
   endtask

   function automatic logic [31:0] mword(input logic [AW-1:0] a);
      return {mmem[AW'(a + 10'd3)], mmem[AW'(a + 10'd2)], mmem[AW'(a + 10'd1)], mmem[a]};
   endfunction

   // One clock: check outputs for the current inputs, then advance RAM and model over the edge.
   task automatic tick();
      logic e_en, e_we, e_rdy, e_gnt, e_done;
      logic [AW-1:0] e_addr, wa, base;
      logic [7:0] e_din, wd;
      logic w;
      bit busy;
      wr_t item;
      #1;
      busy   = pend.size() != 0;
      e_rdy  = !rst && !busy;
      e_gnt  = !rst && !busy && bus.fetch_req;
      e_en   = !rst && (busy || bus.fetch_req);
      e_we   = !rst && busy;
      e_done = !rst && busy && pend.size() == 1;
      e_addr = busy ? pend[0].a : (bus.fetch_req ? bus.fetch_addr : last_addr);
      e_din  = busy ? pend[0].d : last_din;

      check("ld_ready", bus.ld_ready, e_rdy);
      check("fetch_gnt", bus.fetch_gnt, e_gnt);
      check("ram_en", bus.ram_en, e_en);
      check("ram_we", bus.ram_we, e_we);
      check("ld_done", bus.ld_done, e_done);
      check("ld_count", bus.ld_count, exp_cnt);
      check("fetch_valid", bus.fetch_valid, exp_fv);
      if (exp_fv || rst) check("fetch_data", bus.fetch_data, exp_fd);
      if (!rst && (e_en || have_addr)) check("ram_addr", bus.ram_addr, e_addr);
      if (!rst && (e_we || have_din)) check("ram_din", bus.ram_din, e_din);

      if (bus.fetch_gnt) begin
         n_gnt++;
         cur_gap = 0;
      end else begin
         cur_gap++;
         if (cur_gap > max_gap) max_gap = cur_gap;
      end
      if (bus.ld_done) n_done++;
      w  = bus.ram_en && bus.ram_we;
      wa = bus.ram_addr;
      wd = bus.ram_din;

      @(posedge clk);
      if (w) ram[wa] = wd;
      if (rst) begin
         reset_model();
      end else begin
         exp_fv = e_gnt;
         if (e_gnt) exp_fd = mword(bus.fetch_addr);
         if (e_en) begin
            last_addr = e_addr;
            have_addr = 1'b1;
         end
         if (busy) begin
            item = pend.pop_front();
            mmem[item.a] = item.d;
            last_din = item.d;
            have_din = 1'b1;
            if (pend.size() == 0 && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
         end else if (bus.ld_valid) begin
            base = bus.ld_addr - (bus.ld_addr % 4);
            for (int k = 0; k < 4; k++)
               pend.push_back('{a: AW'(base + k), d: 8'(bus.ld_data >> (8 * k))});
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] w;
      logic [31:0] sw;
      int mism;

      for (int i = 0; i < DEPTH; i++) begin
         ram[i] = 8'h00;
         mmem[i] = 8'h00;
      end
      last_addr = '0;
      last_din = '0;
      n_gnt = 0; n_done = 0; cur_gap = 0; max_gap = 0;

      // Reset with both requesters active.
      bus.fetch_req = 1'b1; bus.fetch_addr = 10'h055;
      bus.ld_valid = 1'b1; bus.ld_addr = 10'h100; bus.ld_data = 32'h01020304;
      sbus.ld_valid = 1'b0; sbus.ld_addr = 2'd0; sbus.ld_data = 32'h0;
      apply_rst(1'b1);
      @(negedge clk);
      tick();
      tick();
      #1;
      check("rst_ram_en", bus.ram_en, 1'b0);
      check("rst_ram_we", bus.ram_we, 1'b0);
      check("rst_ld_ready", bus.ld_ready, 1'b0);
      check("rst_fetch_gnt", bus.fetch_gnt, 1'b0);
      check("rst_fetch_valid", bus.fetch_valid, 1'b0);
      check("rst_ld_count", bus.ld_count, 16'h0);
      bus.fetch_req = 1'b0; bus.ld_valid = 1'b0;
      apply_rst(1'b0);
      tick();

      // Single word load and read-back.
      w = 32'hDEADBEEF;
      bus.ld_valid = 1'b1; bus.ld_addr = 10'h010; bus.ld_data = w;
      tick();
      bus.ld_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("single_addr", bus.ram_addr, 32'h010 + k);
         check("single_din", bus.ram_din, 8'(w >> (8 * k)));
         tick();
      end
      #1;
      check("single_count", bus.ld_count, 16'd1);
      bus.fetch_req = 1'b1; bus.fetch_addr = 10'h010;
      tick();
      bus.fetch_req = 1'b0;
      #1;
      check("single_fetch_valid", bus.fetch_valid, 1'b1);
      check("single_fetch_data", bus.fetch_data, 32'hDEADBEEF);
      tick();

      // Reset in the middle of a burst: only the WR0 byte lands.
      bus.ld_valid = 1'b1; bus.ld_addr = 10'h020; bus.ld_data = 32'h11223344;
      tick();
      bus.ld_valid = 1'b0;
      tick();
      apply_rst(1'b1);
      tick();
      check("midrst_byte0", ram[10'h020], 8'h44);
      check("midrst_byte1", ram[10'h021], 8'h00);
      check("midrst_byte2", ram[10'h022], 8'h00);
      check("midrst_byte3", ram[10'h023], 8'h00);
      apply_rst(1'b0);
      tick();
      tick();

      // Contention: both held high for 20 cycles.
      n_gnt = 0; n_done = 0; cur_gap = 0; max_gap = 0;
      bus.fetch_req = 1'b1;
      bus.ld_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.fetch_addr = 10'($urandom);
         bus.ld_addr = 10'h200 + 10'($urandom_range(0, 255));
         bus.ld_data = $urandom;
         tick();
      end
      check("cont_grants", n_gnt, 4);
      check("cont_words", n_done, 4);
      check("cont_max_gap", max_gap, 4);
      bus.fetch_req = 1'b0; bus.ld_valid = 1'b0;
      tick();

      // Misaligned address at the top of memory, plus the two-bit-address instance.
      w = $urandom;
      sw = 32'hA1B2C3D4;
      bus.ld_valid = 1'b1; bus.ld_addr = 10'h3FE; bus.ld_data = w;
      sbus.ld_valid = 1'b1; sbus.ld_addr = 2'd3; sbus.ld_data = sw;
      tick();
      bus.ld_valid = 1'b0; sbus.ld_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.ld_addr = 10'($urandom);
         bus.ld_data = $urandom;
         sbus.ld_addr = 2'($urandom);
         sbus.ld_data = $urandom;
         #1;
         check("wrap_addr", bus.ram_addr, 32'h3FC + k);
         check("wrap_din", bus.ram_din, 8'(w >> (8 * k)));
         check("small_addr", sbus.ram_addr, k);
         check("small_din", sbus.ram_din, 8'(sw >> (8 * k)));
         check("small_we", sbus.ram_we, 1'b1);
         tick();
      end
      #1;
      check("small_done_idle", sbus.ld_ready, 1'b1);
      check("small_count", sbus.ld_count, 16'd1);

      // Random traffic against the model, inputs changing every cycle.
      for (int i = 0; i < 600; i++) begin
         bus.fetch_req = 1'($urandom_range(0, 1));
         bus.fetch_addr = 10'($urandom);
         bus.ld_valid = ($urandom_range(0, 2) == 0);
         bus.ld_addr = 10'($urandom);
         bus.ld_data = $urandom;
         tick();
      end
      bus.fetch_req = 1'b0; bus.ld_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      mism = 0;
      for (int i = 0; i < DEPTH; i++) if (ram[i] !== mmem[i]) mism++;
      check("mem_contents", mism, 0);

      // Saturation: preload the counter, then complete two more words.
      force dut.ld_count_q = 16'hFFFE;
      exp_cnt = 16'hFFFE;
      tick();
      release dut.ld_count_q;
      tick();
      for (int j = 0; j < 2; j++) begin
         bus.ld_valid = 1'b1; bus.ld_addr = 10'($urandom); bus.ld_data = $urandom;
         tick();
         bus.ld_valid = 1'b0;
         for (int k = 0; k < 4; k++) tick();
         #1;
         check("sat_count", bus.ld_count, 16'hFFFF);
      end
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/inst_ram_arb.md
# inst_ram_arb

Arbiter and sequencer for the single-port, byte-wide instruction RAM. It shares the one RAM port between two requesters. The core fetch unit reads 32-bit little-endian words. The program loader writes 32-bit words, and the arbiter serialises each loader word into four byte writes. The block sits between the fetch stage / loader and the instruction RAM, and it owns `addr`, `din`, `en` and `we` of that RAM.

## Interface
- `ADDR_W`, default 10: RAM byte-address width, equal to $clog2(`INST_DEPTH`).
- `MEM_W`, default 8: RAM cell width, equal to `INST_MEM_WIDTH`.
- `INST_W`, default 32: instruction width, equal to `INST_WIDTH`.

Ports:
- `clk`  in  1  single clock for all state.
- `rst`  in  1  asynchronous, active-high reset.
- `fetch_req`  in  1  fetch read request.
- `fetch_addr`  in  ADDR_W  fetch byte address, passed unmodified.
- `fetch_gnt`  out  1  fetch uses the RAM port this cycle.
- `fetch_valid`  out  1  `fetch_data` holds the word for the previous granted request.
- `fetch_data`  out  INST_W  registered read word.
- `ld_valid`  in  1  loader word write request.
- `ld_ready`  out  1  arbiter accepts a loader word this cycle.
- `ld_addr`  in  ADDR_W  loader byte address; bits [1:0] are ignored (forced to 0).
- `ld_data`  in  INST_W  loader word, little-endian.
- `ld_done`  out  1  one-cycle pulse on the final byte write of a word.
- `ld_count`  out  16  count of completed loader words, saturating at 16'hFFFF.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_din`  out  MEM_W  RAM write byte.
- `ram_en`  out  1  RAM enable.
- `ram_we`  out  1  RAM write enable.
- `ram_dout`  in  INST_W  combinational RAM read word.

## Operation
The FSM has five states: IDLE, WR0, WR1, WR2, WR3.

**IDLE**
- `ld_ready` = 1.
- `fetch_gnt` = `fetch_req`; when granted, `ram_en` = 1, `ram_we` = 0, `ram_addr` = `fetch_addr`.
- When `ld_valid` is high, the handshake completes. `{ld_addr[ADDR_W-1:2],2'b00}` is captured into `base` and `ld_data` into `wdata`, then the FSM moves to WR0.
- The accept cycle does not use the RAM port, so a fetch grant and a loader accept may occur in the same cycle.

**WRk (k = 0..3)**
- `ram_en` = 1, `ram_we` = 1.
- `ram_addr` = `base + k`, modulo 2^ADDR_W (wraps at the top of memory).
- `ram_din` = `wdata[8k+7:8k]`.
- `ld_ready` = 0 and `fetch_gnt` = 0; a pending `fetch_req` waits.
- WRk advances to WRk+1; WR3 returns to IDLE.

**Completion**
- In WR3, `ld_done` = 1 and `ld_count` increments (no increment once at 16'hFFFF).

**Fetch path and fairness**
- `fetch_data` <= `ram_dout` and `fetch_valid` <= `fetch_gnt`, registered every cycle.
- Loader words are never interrupted once accepted.
- Every write burst is followed by at least one IDLE cycle, so fetch is granted at least once in every 5 cycles while requesting.

**Idle port**
- When neither requester is active, `ram_en` = `ram_we` = 0.
- `ram_addr` holds its last value; `ram_din` holds its last value.

## Timing
**Reset**
- Asynchronous assertion forces state IDLE, `fetch_valid` = 0, `fetch_data` = 0, `ld_count` = 0, `ld_done` = 0, `base` = 0, `wdata` = 0.
- While `rst` is high, `ram_en` = `ram_we` = `fetch_gnt` = `ld_ready` = 0 regardless of inputs.
- Reset mid-burst abandons the word. Bytes already written stay in the RAM, and `ld_count` does not increment.

**Fetch**
- Request granted in cycle N gives `fetch_valid` = 1 with data in cycle N+1.
- A request held across WR states is granted in the first IDLE cycle after them.

**Loader**
- Accepted in cycle N: byte writes occur in N+1..N+4, `ld_done` is high in N+4, and `ld_ready` is high again in N+5.
- Back-to-back words achieve a throughput of 1 word per 5 cycles.

**Simultaneous `fetch_req` and `ld_valid` in IDLE**
- Both are served in that cycle: fetch gets the port, the loader is accepted.

**Loader signals**
- `ld_addr` and `ld_data` are sampled only on the handshake. Changes during WR states have no effect.

## Test plan
- **Reset values.** Assert `rst` with `fetch_req` = `ld_valid` = 1. Required: all RAM-side enables 0, `fetch_valid` = 0, `ld_count` = 0, `ld_ready` = 0.
- **Single word load.** Send `ld_addr` = 0x010, `ld_data` = 0xDEADBEEF. Required: writes 0xEF@0x010, 0xBE@0x011, 0xAD@0x012, 0xDE@0x013 in cycles N+1..N+4, `ld_done` at N+4, `ld_count` = 1. A fetch at 0x010 afterwards returns 0xDEADBEEF one cycle after grant.
- **Contention.** Hold `fetch_req` and `ld_valid` high for 20 cycles. Required: `fetch_gnt` pulses every 5th cycle, coinciding with `ld_ready`, 4 words written, no fetch gap longer than 4 cycles.
- **Misalign and wrap.** Send `ld_addr` = 0x3FE with ADDR_W = 10. Required: writes at 0x3FC..0x3FF. Then `ld_addr` = 0x3FC with `base` wrap checked via an ADDR_W = 2 instance: addresses 0,1,2,3.
- **Reset mid-burst.** Accept 0x11223344 at 0x020 and assert `rst` during WR1. Required: only 0x44@0x020 is written, `ld_count` unchanged, FSM returns to IDLE and `ld_ready` = 1 after deassertion.
- **Saturation.** Preload `ld_count` to 16'hFFFE via 65534 words (or force), then load 2 more words. Required: `ld_count` = 16'hFFFF and stays there.
